// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the fetch/decode pipeline sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned MC_CNT_W      = 4;
  localparam int unsigned MC_CYCLES_MIN = 2;
  localparam int unsigned MC_CYCLES_MAX = 15;

  typedef enum logic [1:0] {
    PS_RUN   = 2'd0,
    PS_MULTI = 2'd1,
    PS_HALT  = 2'd2
  } pipe_state_t;

  typedef logic [MC_CNT_W-1:0] mc_cnt_t;

  // True when a multi-cycle occupancy fits the counter and keeps start/last distinct.
  function automatic logic cycles_legal(input int unsigned n);
    return (n >= MC_CYCLES_MIN) && (n <= MC_CYCLES_MAX);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Decoder/execute status in, pipeline enables and strobes out.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic    dec_valid;
  logic    dec_mc;
  logic    dec_is_dv;
  logic    dec_halt;
  logic    dec_prefix;
  logic    ex_branch;
  logic    ext_stall;

  logic    fetch_en;
  logic    dec_en;
  logic    flush;
  logic    alu_start;
  logic    alu_last;
  mc_cnt_t mc_count;
  logic    prefix_pending;
  logic    halted;

  // Core side: drives decode/execute status, consumes the gating signals.
  modport master (
    output dec_valid, dec_mc, dec_is_dv, dec_halt, dec_prefix, ex_branch, ext_stall,
    input  fetch_en, dec_en, flush, alu_start, alu_last, mc_count, prefix_pending, halted
  );

  // Sequencer side.
  modport slave (
    input  dec_valid, dec_mc, dec_is_dv, dec_halt, dec_prefix, ex_branch, ext_stall,
    output fetch_en, dec_en, flush, alu_start, alu_last, mc_count, prefix_pending, halted
  );

endinterface

// File: rtl/pipe_ctrl_mc_down_counter.sv
// Down-counter with load/enable and a registered "count is one" flag.
module mc_down_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned W = MC_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] count_o,
  output logic         is_one_o
);

  logic [W-1:0] count_q, count_d;
  logic         is_one_q, is_one_d;

  // Load wins over decrement; the count saturates at zero.
  always_comb begin
    count_d  = count_q;
    is_one_d = is_one_q;
    if (load_i) begin
      count_d  = load_val_i;
      is_one_d = (load_val_i == W'(1));
    end else if (en_i && (count_q != '0)) begin
      count_d  = count_q - W'(1);
      is_one_d = (count_q == W'(2));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      is_one_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      is_one_q <= is_one_d;
    end
  end

  assign count_o  = count_q;
  assign is_one_o = is_one_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stalls fetch/decode for MP/DV, flushes on taken branch,
// tracks a pending EXTEND/INDEX prefix and parks the core on HALT.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MP_CYCLES = 3,
  parameter int unsigned DV_CYCLES = 6
) (
  input  logic         clock,
  input  logic         rst_l,
  pipe_ctrl_if.slave   bus
);

  if (!cycles_legal(MP_CYCLES)) begin : g_bad_mp_cycles
    $error("pipe_ctrl: MP_CYCLES out of range 2..15");
  end
  if (!cycles_legal(DV_CYCLES)) begin : g_bad_dv_cycles
    $error("pipe_ctrl: DV_CYCLES out of range 2..15");
  end

  localparam mc_cnt_t MP_LOAD = MC_CNT_W'(MP_CYCLES - 1);
  localparam mc_cnt_t DV_LOAD = MC_CNT_W'(DV_CYCLES - 1);

  pipe_state_t state_q, state_d;
  logic        prefix_q, prefix_d;

  logic        fetch_en_c;
  logic        dec_en_c;
  logic        flush_c;
  logic        alu_start_c;
  logic        alu_last_c;
  logic        halted_c;
  logic        cnt_load;
  logic        cnt_en;
  mc_cnt_t     cnt_load_val;
  mc_cnt_t     cnt_value;
  logic        cnt_is_one;

  mc_down_counter #(
    .W (MC_CNT_W)
  ) u_mc_cnt (
    .clk        (clock),
    .rst_n      (rst_l),
    .load_i     (cnt_load),
    .en_i       (cnt_en),
    .load_val_i (cnt_load_val),
    .count_o    (cnt_value),
    .is_one_o   (cnt_is_one)
  );

  // Next state and gating; branch beats stall beats halt beats multi-cycle.
  always_comb begin
    state_d      = state_q;
    fetch_en_c   = 1'b0;
    dec_en_c     = 1'b0;
    flush_c      = 1'b0;
    alu_start_c  = 1'b0;
    alu_last_c   = 1'b0;
    halted_c     = 1'b0;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    cnt_load_val = '0;

    unique case (state_q)
      PS_RUN: begin
        fetch_en_c = !bus.ext_stall;
        dec_en_c   = !bus.ext_stall;
        if (bus.ex_branch) begin
          flush_c = 1'b1;
        end else if (bus.ext_stall) begin
          state_d = PS_RUN;
        end else if (bus.dec_valid && bus.dec_halt) begin
          fetch_en_c = 1'b0;
          dec_en_c   = 1'b0;
          state_d    = PS_HALT;
        end else if (bus.dec_valid && bus.dec_mc) begin
          fetch_en_c   = 1'b0;
          dec_en_c     = 1'b0;
          alu_start_c  = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = bus.dec_is_dv ? DV_LOAD : MP_LOAD;
          state_d      = PS_MULTI;
        end
      end
      PS_MULTI: begin
        alu_last_c = cnt_is_one;
        cnt_en     = !bus.ext_stall;
        if (cnt_is_one && !bus.ext_stall) begin
          state_d = PS_RUN;
        end
      end
      PS_HALT: begin
        halted_c = 1'b1;
      end
      default: begin
        state_d = PS_RUN;
      end
    endcase
  end

  // Prefix flag: flush and the multi-cycle acceptance clear it, accepted words load it.
  always_comb begin
    prefix_d = prefix_q;
    if (flush_c || alu_start_c) begin
      prefix_d = 1'b0;
    end else if (bus.dec_valid && dec_en_c) begin
      prefix_d = bus.dec_prefix;
    end
  end

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= PS_RUN;
      prefix_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prefix_q <= prefix_d;
    end
  end

  // Combinational strobes are forced low while reset is held.
  assign bus.fetch_en       = rst_l & fetch_en_c;
  assign bus.dec_en         = rst_l & dec_en_c;
  assign bus.flush          = rst_l & flush_c;
  assign bus.alu_start      = rst_l & alu_start_c;
  assign bus.alu_last       = rst_l & alu_last_c;
  assign bus.halted         = rst_l & halted_c;
  assign bus.mc_count       = cnt_value;
  assign bus.prefix_pending = prefix_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed cycle-by-cycle bench for pipe_ctrl with MP_CYCLES=3, DV_CYCLES=6.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk;
  logic rst_l;
  int   checks;
  int   errors;

  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .MP_CYCLES (3),
    .DV_CYCLES (6)
  ) dut (
    .clock (clk),
    .rst_l (rst_l),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in  = {valid, mc, is_dv, halt, prefix, branch, stall}
  // exp = {fetch_en, dec_en, flush, alu_start, alu_last, mc_count[3:0], prefix_pending, halted}
  typedef struct {
    string       name;
    logic [6:0]  in;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input string n, input logic [6:0] i,
                              input logic [4:0] s, input logic [3:0] c, input logic [1:0] ph);
    vec_t v;
    v.name = n;
    v.in   = i;
    v.exp  = {s, c, ph};
    tbl.push_back(v);
  endfunction

  task automatic drive(input logic [6:0] i);
    {bus.dec_valid, bus.dec_mc, bus.dec_is_dv, bus.dec_halt,
     bus.dec_prefix, bus.ex_branch, bus.ext_stall} = i;
  endtask

  task automatic check(input string n, input logic [10:0] exp);
    logic [10:0] act;
    act = {bus.fetch_en, bus.dec_en, bus.flush, bus.alu_start, bus.alu_last,
           bus.mc_count, bus.prefix_pending, bus.halted};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b_%h_%b required %b_%h_%b", n,
               act[10:6], act[5:2], act[1:0], exp[10:6], exp[5:2], exp[1:0]);
    end
  endtask

  task automatic apply(input vec_t v);
    drive(v.in);
    @(negedge clk);
    check(v.name, v.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_one(input string n, input logic [6:0] i,
                           input logic [4:0] s, input logic [3:0] c, input logic [1:0] ph);
    vec_t v;
    v.name = n;
    v.in   = i;
    v.exp  = {s, c, ph};
    apply(v);
  endtask

  task automatic reset_pulse(input string n);
    rst_l = 1'b0;
    @(negedge clk);
    check(n, 11'b0);
    @(posedge clk);
    #1;
    check({n, "_hold"}, 11'b0);
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // A taken branch while the sequencer holds the pipe in MULTI is illegal stimulus.
  always @(negedge clk) begin
    if (rst_l && bus.ex_branch && !bus.halted && !bus.ext_stall)
      assert (bus.fetch_en) else $error("FAIL ex_branch_in_multi: fetch_en %b", bus.fetch_en);
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_l  = 1'b0;
    drive(7'b1000000);

    add("plain0",       7'b1000000, 5'b11000, 4'd0, 2'b00);
    add("plain1",       7'b1000000, 5'b11000, 4'd0, 2'b00);
    add("plain2",       7'b1000000, 5'b11000, 4'd0, 2'b00);
    add("mp_acc",       7'b1100000, 5'b00010, 4'd0, 2'b00);
    add("mp_m2",        7'b0000000, 5'b00000, 4'd2, 2'b00);
    add("mp_m1",        7'b0000000, 5'b00001, 4'd1, 2'b00);
    add("mp_done",      7'b1000000, 5'b11000, 4'd0, 2'b00);
    add("dv_acc",       7'b1110000, 5'b00010, 4'd0, 2'b00);
    add("dv_m5",        7'b0000000, 5'b00000, 4'd5, 2'b00);
    add("dv_m4",        7'b0000000, 5'b00000, 4'd4, 2'b00);
    add("dv_stall_a",   7'b0000001, 5'b00000, 4'd3, 2'b00);
    add("dv_stall_b",   7'b0000001, 5'b00000, 4'd3, 2'b00);
    add("dv_m3",        7'b0000000, 5'b00000, 4'd3, 2'b00);
    add("dv_m2",        7'b0000000, 5'b00000, 4'd2, 2'b00);
    add("dv_m1",        7'b0000000, 5'b00001, 4'd1, 2'b00);
    add("dv_done",      7'b0000000, 5'b11000, 4'd0, 2'b00);
    add("br_halt",      7'b1001010, 5'b11100, 4'd0, 2'b00);
    add("after_br",     7'b1000000, 5'b11000, 4'd0, 2'b00);
    add("br_mc",        7'b1100010, 5'b11100, 4'd0, 2'b00);
    add("after_brmc",   7'b1000000, 5'b11000, 4'd0, 2'b00);
    add("run_stall_mc", 7'b1100001, 5'b00000, 4'd0, 2'b00);
    add("after_stall",  7'b1000000, 5'b11000, 4'd0, 2'b00);
    add("ext_acc",      7'b1000100, 5'b11000, 4'd0, 2'b00);
    add("ext_br",       7'b1000010, 5'b11100, 4'd0, 2'b10);
    add("after_flush",  7'b1000000, 5'b11000, 4'd0, 2'b00);
    add("ext2",         7'b1000100, 5'b11000, 4'd0, 2'b00);
    add("ext3",         7'b1000100, 5'b11000, 4'd0, 2'b10);
    add("pfx_stall",    7'b1000001, 5'b00000, 4'd0, 2'b10);
    add("dv_pfx_acc",   7'b1110000, 5'b00010, 4'd0, 2'b10);
    add("dvp_m5",       7'b0000000, 5'b00000, 4'd5, 2'b00);
    add("dvp_m4",       7'b0000000, 5'b00000, 4'd4, 2'b00);
    add("dvp_m3",       7'b0000000, 5'b00000, 4'd3, 2'b00);
    add("dvp_m2",       7'b0000000, 5'b00000, 4'd2, 2'b00);
    add("dvp_m1",       7'b0000000, 5'b00001, 4'd1, 2'b00);
    add("dvp_done",     7'b1000000, 5'b11000, 4'd0, 2'b00);
    add("ext4",         7'b1000100, 5'b11000, 4'd0, 2'b00);
    add("plain_clr",    7'b1000000, 5'b11000, 4'd0, 2'b10);
    add("plain_after",  7'b1000000, 5'b11000, 4'd0, 2'b00);
    add("halt_acc",     7'b1001000, 5'b00000, 4'd0, 2'b00);
    add("halted",       7'b1000000, 5'b00000, 4'd0, 2'b01);
    add("halted_mc",    7'b1100000, 5'b00000, 4'd0, 2'b01);
    add("halted_stall", 7'b0000001, 5'b00000, 4'd0, 2'b01);

    @(negedge clk);
    check("reset_held", 11'b0);
    @(posedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    for (int i = 0; i < 8; i++)
      apply_one($sformatf("halt_sticky%0d", i), 7'b1000000, 5'b00000, 4'd0, 2'b01);

    drive(7'b1000000);
    reset_pulse("rst_in_halt");
    apply_one("run_after_halt_rst", 7'b1000000, 5'b11000, 4'd0, 2'b00);

    apply_one("mp2_acc",  7'b1100000, 5'b00010, 4'd0, 2'b00);
    apply_one("mp2_m2",   7'b0000000, 5'b00000, 4'd2, 2'b00);
    drive(7'b0000000);
    reset_pulse("rst_in_multi");
    apply_one("run_after_multi_rst", 7'b1000000, 5'b11000, 4'd0, 2'b00);

    apply_one("ext_before_rst", 7'b1000100, 5'b11000, 4'd0, 2'b00);
    drive(7'b1000000);
    reset_pulse("rst_with_prefix");
    apply_one("pfx_after_rst", 7'b1000000, 5'b11000, 4'd0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
